// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame defaults
// common to the receive and transmit paths.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input. Resets to 1 so an
// idle-high line does not look like activity coming out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes rx, finds the start bit, samples each bit at
// mid-period, shifts data in LSB first, checks parity and stop, and pulses
// rx_valid once per frame that survives the start-bit check.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);

  rx_state_t            state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sr;
  logic                 perr_next;
  logic                 rx_s;
  logic                 sample;
  logic                 cnt_run;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: every exit from a timed state happens on its sample strobe.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!rx_s)  state_nxt = START;
      START:     if (sample) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (sample && bit_cnt == LAST_BIT)
                   state_nxt = HAS_PAR ? PARITY : STOP;
      PARITY:    if (sample) state_nxt = STOP;
      STOP:      if (sample) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s)   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM: the mid-bit sample strobe, counter enable and busy.
  always_comb begin
    sample  = 1'b0;
    cnt_run = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      START: begin
        cnt_run = 1'b1;
        sample  = (cnt == HALF_M1);
      end
      DATA, PARITY, STOP: begin
        cnt_run = 1'b1;
        sample  = (cnt == FULL_M1);
      end
      default: ;
    endcase
  end

  // Cycle counter: held at 0 in untimed states, restarts after each sample,
  // which also covers every entry into a timed state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (!cnt_run || sample) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  // Shift register, bit counter and parity result for the frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr        <= '1;
      bit_cnt   <= '0;
      perr_next <= 1'b0;
    end else if (sample) begin
      if (state == DATA) begin
        sr      <= {rx_s, sr[DATA_BITS-1:1]};
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if (state == PARITY)
        perr_next <= (^sr) ^ rx_s ^ ODD;
    end
  end

  // Frame delivery: on the stop sample, publish data and flags and raise
  // rx_valid for the following cycle only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= (state == STOP) && sample;
      if ((state == STOP) && sample) begin
        rx_data    <= sr;
        parity_err <= HAS_PAR ? perr_next : 1'b0;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule
